// File: rtl/tbus_enable_arbiter.sv
// Round-robin owner arbiter for a wired tristate net; drives one-hot-or-zero EN with a dead gap between owners.
// Grant appears one cycle after a request is sampled in IDLE; each hand-over inserts TURN_GAP all-off cycles.
module tbus_enable_arbiter #(
  parameter int N_REQ    = 4,
  parameter int TURN_GAP = 1,
  parameter int MAX_HOLD = 8,
  parameter int OW       = $clog2(N_REQ)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_REQ-1:0] REQ,
  output logic [N_REQ-1:0] EN,
  output logic [OW-1:0]    OWNER,
  output logic             BUSY,
  output logic             GAP
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DEAD} state_t;

  localparam logic [OW:0]   N_W      = (OW+1)'(N_REQ);
  localparam logic [OW-1:0] LAST_IDX = OW'(N_REQ-1);
  localparam logic [7:0]    HOLD_LIM = 8'(MAX_HOLD-1);
  localparam logic [3:0]    GAP_INIT = 4'(TURN_GAP-1);

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   en_q, en_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic               busy_q;
  logic               gap_q, gap_d;
  logic [OW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [7:0]         hold_cnt_q, hold_cnt_d;
  logic [3:0]         gap_cnt_q, gap_cnt_d;

  logic [2*N_REQ-1:0] req_rot;
  logic [N_REQ-1:0]   req_win;
  logic [OW-1:0]      off;
  logic [OW:0]        sum;
  logic [OW-1:0]      winner;
  logic               any_req, own_req, other_req, do_grant;

  // Rotate requests so rr_ptr sits at bit 0; the lowest set bit is the winner's offset.
  always_comb begin
    req_rot = {REQ, REQ} >> rr_ptr_q;
    req_win = req_rot[N_REQ-1:0];
    off     = '0;
    for (int j = N_REQ-1; j >= 0; j--) begin
      if (req_win[j]) off = OW'(j);
    end
    sum = {1'b0, rr_ptr_q} + {1'b0, off};
    if (sum >= N_W) sum = sum - N_W;
    winner = sum[OW-1:0];
  end

  assign any_req   = |REQ;
  assign own_req   = |(REQ & en_q);
  assign other_req = |(REQ & ~en_q);

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    owner_d    = owner_q;
    gap_d      = gap_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    do_grant   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req) do_grant = 1'b1;
      end
      S_DRIVE: begin
        if (hold_cnt_q != HOLD_LIM) hold_cnt_d = hold_cnt_q + 8'd1;
        // A dropped request and an expired hold on the same edge collapse into one release.
        if (!own_req || (hold_cnt_q == HOLD_LIM && other_req)) begin
          en_d      = '0;
          gap_d     = 1'b1;
          gap_cnt_d = GAP_INIT;
          state_d   = S_DEAD;
        end
      end
      S_DEAD: begin
        if (gap_cnt_q == 4'd0) begin
          gap_d = 1'b0;
          if (any_req) do_grant = 1'b1;
          else         state_d  = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (do_grant) begin
      en_d         = '0;
      en_d[winner] = 1'b1;
      owner_d      = winner;
      rr_ptr_d     = (winner == LAST_IDX) ? '0 : winner + OW'(1);
      hold_cnt_d   = '0;
      state_d      = S_DRIVE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      en_q       <= '0;
      owner_q    <= '0;
      busy_q     <= 1'b0;
      gap_q      <= 1'b0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      owner_q    <= owner_d;
      busy_q     <= |en_d;
      gap_q      <= gap_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign EN    = en_q;
  assign OWNER = owner_q;
  assign BUSY  = busy_q;
  assign GAP   = gap_q;

endmodule

// File: tb/tb_tbus_enable_arbiter.sv
// Directed bench for tbus_enable_arbiter with N_REQ=4, TURN_GAP=2, MAX_HOLD=4.
module tb_tbus_enable_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] REQ;
  logic [3:0] EN;
  logic [1:0] OWNER;
  logic       BUSY;
  logic       GAP;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  tbus_enable_arbiter #(.N_REQ(4), .TURN_GAP(2), .MAX_HOLD(4)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .EN(EN), .OWNER(OWNER), .BUSY(BUSY), .GAP(GAP)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    REQ = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (!BUSY && !GAP) break;
    end
    checks++;
    if (BUSY !== 1'b0 || GAP !== 1'b0 || EN !== 4'b0000) begin
      errors++;
      $display("FAIL drain_idle got EN=%b BUSY=%b GAP=%b exp EN=0000 BUSY=0 GAP=0", EN, BUSY, GAP);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    REQ = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (EN !== 4'b0000 || BUSY !== 1'b0 || GAP !== 1'b0 || OWNER !== 2'd0) begin
        errors++;
        $display("FAIL reset_state cyc=%0d got EN=%b BUSY=%b GAP=%b OWNER=%0d exp 0000/0/0/0", c, EN, BUSY, GAP, OWNER);
      end
    end
    RST = 1'b0;
    tick();
    checks++;
    if (EN !== 4'b0001 || OWNER !== 2'd0 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL first_grant got EN=%b OWNER=%0d BUSY=%b exp 0001/0/1", EN, OWNER, BUSY);
    end
    drain();
  endtask

  task automatic test_single();
    REQ = 4'b0100;
    tick();
    checks++;
    if (EN !== 4'b0100 || OWNER !== 2'd2 || BUSY !== 1'b1 || GAP !== 1'b0) begin
      errors++;
      $display("FAIL single_grant got EN=%b OWNER=%0d BUSY=%b GAP=%b exp 0100/2/1/0", EN, OWNER, BUSY, GAP);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (EN !== 4'b0100) begin
        errors++;
        $display("FAIL single_hold cyc=%0d got EN=%b exp 0100", c, EN);
      end
    end
    REQ = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (EN !== 4'b0000 || GAP !== 1'b1 || BUSY !== 1'b0) begin
        errors++;
        $display("FAIL single_gap cyc=%0d got EN=%b GAP=%b BUSY=%b exp 0000/1/0", c, EN, GAP, BUSY);
      end
    end
    tick();
    checks++;
    if (EN !== 4'b0000 || GAP !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL single_idle got EN=%b GAP=%b BUSY=%b exp 0000/0/0", EN, GAP, BUSY);
    end
  endtask

  task automatic test_contention();
    logic [3:0] e;
    int o;
    REQ = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      o = (3 + r) % 4;
      e = 4'(1 << o);
      for (int k = 0; k < 4; k++) begin
        tick();
        checks++;
        if (EN !== e || OWNER !== 2'(o) || BUSY !== 1'b1) begin
          errors++;
          $display("FAIL contention_own r=%0d k=%0d got EN=%b OWNER=%0d exp EN=%b OWNER=%0d", r, k, EN, OWNER, e, o);
        end
      end
      if (r < 4) begin
        for (int k = 0; k < 2; k++) begin
          tick();
          checks++;
          if (EN !== 4'b0000 || GAP !== 1'b1) begin
            errors++;
            $display("FAIL contention_gap r=%0d k=%0d got EN=%b GAP=%b exp 0000/1", r, k, EN, GAP);
          end
        end
      end
    end
    // Owner 3 drops on the same edge its hold expires: one release, then client 0.
    REQ = 4'b0111;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (EN !== 4'b0000 || GAP !== 1'b1) begin
        errors++;
        $display("FAIL simul_gap k=%0d got EN=%b GAP=%b exp 0000/1", k, EN, GAP);
      end
    end
    tick();
    checks++;
    if (EN !== 4'b0001 || OWNER !== 2'd0) begin
      errors++;
      $display("FAIL simul_next got EN=%b OWNER=%0d exp 0001/0", EN, OWNER);
    end
    drain();
  endtask

  task automatic test_hold_alone();
    REQ = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (EN !== 4'b0010 || GAP !== 1'b0) begin
        errors++;
        $display("FAIL hold_alone cyc=%0d got EN=%b GAP=%b exp 0010/0", c, EN, GAP);
      end
    end
    drain();
  endtask

  task automatic test_rr_pointer();
    REQ = 4'b0100;
    tick();
    checks++;
    if (EN !== 4'b0100) begin
      errors++;
      $display("FAIL rr_first got EN=%b exp 0100", EN);
    end
    tick();
    REQ = 4'b1001;
    tick();
    checks++;
    if (EN !== 4'b0000 || GAP !== 1'b1) begin
      errors++;
      $display("FAIL rr_gap got EN=%b GAP=%b exp 0000/1", EN, GAP);
    end
    tick();
    tick();
    checks++;
    if (EN !== 4'b1000 || OWNER !== 2'd3) begin
      errors++;
      $display("FAIL rr_next got EN=%b OWNER=%0d exp 1000/3", EN, OWNER);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    REQ = 4'b0100;
    tick();
    checks++;
    if (EN !== 4'b0100) begin
      errors++;
      $display("FAIL rstmid_grant got EN=%b exp 0100", EN);
    end
    tick();
    RST = 1'b1;
    tick();
    checks++;
    if (EN !== 4'b0000 || BUSY !== 1'b0 || GAP !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_off got EN=%b BUSY=%b GAP=%b exp 0000/0/0", EN, BUSY, GAP);
    end
    RST = 1'b0;
    REQ = 4'b0110;
    tick();
    checks++;
    if (EN !== 4'b0010 || OWNER !== 2'd1) begin
      errors++;
      $display("FAIL rstmid_regrant got EN=%b OWNER=%0d exp 0010/1", EN, OWNER);
    end
  endtask

  task automatic test_dead_sampling();
    REQ = 4'b0100;
    tick();
    checks++;
    if (EN !== 4'b0000 || GAP !== 1'b1) begin
      errors++;
      $display("FAIL dead_release got EN=%b GAP=%b exp 0000/1", EN, GAP);
    end
    REQ = 4'b0001;
    tick();
    checks++;
    if (EN !== 4'b0000 || GAP !== 1'b1) begin
      errors++;
      $display("FAIL dead_mid got EN=%b GAP=%b exp 0000/1", EN, GAP);
    end
    REQ = 4'b1000;
    tick();
    checks++;
    if (EN !== 4'b1000 || OWNER !== 2'd3 || GAP !== 1'b0) begin
      errors++;
      $display("FAIL dead_final got EN=%b OWNER=%0d GAP=%b exp 1000/3/0", EN, OWNER, GAP);
    end
    drain();
  endtask

  initial begin
    RST = 1'b1;
    REQ = 4'b0000;
    test_reset();
    test_single();
    test_contention();
    test_hold_alone();
    test_rr_pointer();
    test_reset_mid();
    test_dead_sampling();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tbus_enable_arbiter.md
Name: tbus_enable_arbiter

Overview:
- Round-robin arbiter and enable sequencer for a shared tristate net built from invz_1-class drivers (one EN per driver, outputs wired together).
- Grants the net to one requester at a time and drives that requester's tristate EN.
- Guarantees break-before-make: a programmable number of all-off dead cycles between successive owners, so no two drivers are ever enabled together.
- Sits between the bus clients and the EN pins of the tristate cell row.

Parameters:
- N_REQ, 4, number of requesters/tristate drivers (2..16).
- TURN_GAP, 1, dead cycles with all EN low between owners (1..15; 0 is illegal).
- MAX_HOLD, 8, maximum cycles an owner keeps the net while others wait (2..255).
- OW, $clog2(N_REQ), width of OWNER.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous reset, active-high.
- REQ  input  N_REQ  level request per client; held high while the client wants the net.
- EN  output  N_REQ  registered one-hot-or-zero tristate enables, wired to the driver EN pins.
- OWNER  output  OW  index of the current owner; valid only while BUSY=1.
- BUSY  output  1  high iff any EN bit is high.
- GAP  output  1  high during dead-gap cycles.

Behaviour:
- Interface: one clock, CLK. Reset is synchronous and active-high on RST.
- Reset: on the first CLK edge with RST=1:
  - EN=0, OWNER=0, BUSY=0, GAP=0.
  - State=IDLE, rr_ptr=0, hold_cnt=0, gap_cnt=0.
  - RST mid-DRIVE turns EN off at that edge with no gap. Safe, because only one driver was on.
- Outputs: all are registered. EN never has more than one bit set; this invariant holds at every edge.
- States: IDLE, DRIVE, DEAD.
- Arbitration function (used in IDLE and on the last DEAD cycle):
  - Winner = first set REQ bit searching rr_ptr, rr_ptr+1, … modulo N_REQ.
  - On grant: rr_ptr <= winner+1 (wraps to 0 after N_REQ-1), hold_cnt <= 0.
- IDLE:
  - If any REQ is high at edge k, then EN[winner]=1 after edge k (1-cycle latency) and state becomes DRIVE.
  - Otherwise remain in IDLE.
- DRIVE, evaluated each edge:
  - hold_cnt increments, saturating at MAX_HOLD-1.
  - Release when REQ[OWNER]=0, or when hold_cnt==MAX_HOLD-1 and some other REQ bit is high.
  - On release: EN<=0, GAP<=1, gap_cnt<=TURN_GAP-1, state becomes DEAD.
  - If MAX_HOLD is reached with no other requester, the owner keeps the net indefinitely.
- DEAD:
  - EN=0 and GAP=1 for exactly TURN_GAP cycles.
  - gap_cnt decrements each cycle.
  - On the edge where gap_cnt==0: GAP<=0 and run the arbitration function. Go to DRIVE with the winner, or to IDLE if no REQ is high.
  - The gap always applies, including when the same client re-requests immediately.
- Simultaneous events: an owner dropping REQ on the same edge its hold limit hits is a single release, not two.
- REQ changes during DEAD are sampled only at the final DEAD edge.
- Fairness: with all clients requesting continuously, each gets MAX_HOLD cycles in turn.
  - Any requester waits at most (N_REQ-1)*(MAX_HOLD+TURN_GAP) cycles.
- Single-requester bus: after its owner drops REQ it passes through DEAD before it can re-grant.

Test Plan (N_REQ=4, TURN_GAP=2, MAX_HOLD=4):
- Reset then idle: RST=1 for 2 cycles with REQ=1111 → EN=0000, BUSY=0 throughout. First grant appears 1 cycle after RST falls: EN=0001, OWNER=0.
- Single request: REQ=0100 at edge 5, dropped at edge 9 → EN=0100 during cycles 5..8; EN=0000 and GAP=1 for exactly 2 cycles; then IDLE with BUSY=0.
- Full contention: REQ=1111 held → EN sequence 0001 ×4, 0000 ×2, 0010 ×4, 0000 ×2, 0100 ×4, 0000 ×2, 1000 ×4, then wraps to 0001. Never two EN bits set.
- Hold without competitor: REQ=0010 only, held for 20 cycles → EN=0010 for all 20 cycles, with no forced release.
- Round-robin pointer: owner 2 releases while REQ=1001 → next grant (after the 2 gap cycles) is EN=1000, not 0001.
- Reset mid-DRIVE: EN=0100, assert RST for 1 cycle → EN=0000 at that edge. Next grant with REQ=0110 goes to index 1 because rr_ptr is back at 0.
